lcd_init_seq: RTL and testbench
===============================

LCD_INIT_SEQ -- requirements
Module: lcd_init_seq

Interface
REQ-001 Parameter RESET_LOW_CYCLES, default 160, RESX low time in CLK cycles (10 us at 16 MHz).
REQ-002 Parameter RESET_WAIT_CYCLES, default 1920000, wait after RESX release before the first command (120 ms).
REQ-003 Parameter DELAY_UNIT, default 16000, CLK cycles per delay-entry unit (1 ms).
REQ-004 Parameter ADDR_W, default 8, command-table address width.
REQ-005 CLK  input  1  system clock, 16 MHz, all logic on rising edge.
REQ-006 RST  input  1  asynchronous, active-high reset.
REQ-007 START  input  1  single-cycle request to run the init sequence.
REQ-008 BUSY  output  1  high from the cycle after an accepted START until DONE rises.
REQ-009 DONE  output  1  high while the sequence has completed, until the next accepted START.
REQ-010 RESX  output  1  display hardware reset, active low.
REQ-011 ROM_ADDR  output  ADDR_W  command-table address, registered.
REQ-012 ROM_DATA  input  10  table entry for ROM_ADDR, combinational read: [9]=delay flag, [8]=D/C bit, [7:0]=payload.
REQ-013 TX_VALID  output  1  word valid to the 9-bit 3-wire SPI serializer.
REQ-014 TX_WORD  output  9  {D/C, byte} to the serializer; held stable while TX_VALID=1.
REQ-015 TX_READY  input  1  serializer accepts TX_WORD on a cycle where TX_VALID and TX_READY are both 1.

Function
REQ-016 FSM states: IDLE, RST_LOW, RST_WAIT, FETCH, SEND, DELAY, FIN.
REQ-017 IDLE or FIN with START=1 -> RST_LOW next cycle; ROM_ADDR:=0, DONE:=0, BUSY:=1.
REQ-018 START in any other state is ignored.
REQ-019 RST_LOW: RESX=0 for exactly RESET_LOW_CYCLES cycles, then RST_WAIT.
REQ-020 RST_WAIT: RESX=1 for exactly RESET_WAIT_CYCLES cycles, then FETCH.
REQ-021 RESX stays 1 in all later states, including FIN.
REQ-022 FETCH decodes ROM_DATA in one cycle.
REQ-023 FETCH, entry[9]=0 -> SEND with TX_WORD:=entry[8:0] and TX_VALID:=1 on the next cycle.
REQ-024 FETCH, entry[9]=1 with payload>0 -> DELAY, loading a down-counter with payload*DELAY_UNIT.
REQ-025 FETCH, entry = 10'h200 (delay flag, payload 0) -> end marker -> FIN.
REQ-026 SEND: TX_VALID held until a handshake; on the handshake cycle TX_VALID:=0 next cycle, ROM_ADDR increments, state -> FETCH.
REQ-027 DELAY: exactly payload*DELAY_UNIT cycles in DELAY, then ROM_ADDR increments and state -> FETCH.
REQ-028 Delay counter width is sufficient for 255*DELAY_UNIT with no overflow.
REQ-029 Command throughput: one word per handshake plus one FETCH cycle.
REQ-030 Address end: after the entry at address 2^ADDR_W-1 is consumed, state -> FIN without wrapping, even if no end marker was seen.
REQ-031 FIN: DONE=1, BUSY=0, TX_VALID=0, ROM_ADDR holds its last value.
REQ-032 TX_READY while TX_VALID=0 has no effect.

Reset
REQ-033 RST=1 asynchronously forces: state IDLE, RESX=0, BUSY=0, DONE=0, TX_VALID=0, TX_WORD=0, ROM_ADDR=0, all counters 0.
REQ-034 RST asserted mid-sequence, including during SEND with TX_VALID=1, drops TX_VALID immediately and aborts with no further handshake.
REQ-035 After RST deasserts the block stays in IDLE until START.

Verification
Bench parameters: RESET_LOW_CYCLES=4, RESET_WAIT_CYCLES=8, DELAY_UNIT=3.
REQ-036 Reset/start timing: RST pulse, then START -> RESX=0 for exactly 4 cycles, then RESX=1; FETCH of address 0 occurs 8 cycles after the RESX rise.
REQ-037 Command stream: table {0x011, 0x129, 0x200}, TX_READY tied 1 -> TX_WORD 0x011 then 0x129, each TX_VALID for 1 cycle; DONE=1 after the end marker; ROM_ADDR=2.
REQ-038 Back-pressure: TX_READY low for 5 cycles on the first word -> TX_VALID=1 and TX_WORD=0x011 held stable all 5 cycles; exactly one transfer on TX_READY rise.
REQ-039 Delay entry: table {0x205, 0x0A5, 0x200} -> 15 cycles of DELAY with no TX_VALID, then word 0x0A5, then DONE.
REQ-040 Abort/restart: RST during a delay -> RESX=0 and BUSY=0 immediately; START ignored while BUSY; START in FIN reruns the full sequence from address 0 with RESX pulsed low again.
REQ-041 Address end: a table containing no end marker gives FIN after 256 entries, ROM_ADDR=255 with no wrap.

Source files
------------

// File: rtl/lcd_init_seq_if.sv
// rtl/lcd_init_seq_if.sv - command-table read port and serializer handshake for lcd_init_seq
interface lcd_init_seq_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic [9:0]        rom_data;
  logic              tx_valid;
  logic [8:0]        tx_word;
  logic              tx_ready;

  modport master (
    output rom_addr,
    output tx_valid,
    output tx_word,
    input  rom_data,
    input  tx_ready
  );

  modport slave (
    input  rom_addr,
    input  tx_valid,
    input  tx_word,
    output rom_data,
    output tx_ready
  );
endinterface

// File: rtl/lcd_init_seq.sv
// rtl/lcd_init_seq.sv - LCD power-up sequencer: RESX pulse, settle wait, then a table of
// 9-bit SPI words and millisecond delays terminated by an end marker or the table end.
module lcd_init_seq #(
  parameter int RESET_LOW_CYCLES  = 160,
  parameter int RESET_WAIT_CYCLES = 1920000,
  parameter int DELAY_UNIT        = 16000,
  parameter int ADDR_W            = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           resx_o,
  lcd_init_seq_if.master bus
);

  localparam int MAX_DELAY = 255 * DELAY_UNIT;
  localparam int MAX_A     = (MAX_DELAY > RESET_WAIT_CYCLES) ? MAX_DELAY : RESET_WAIT_CYCLES;
  localparam int MAX_CNT   = (MAX_A > RESET_LOW_CYCLES) ? MAX_A : RESET_LOW_CYCLES;
  localparam int CNT_W     = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0]  LOW_LAST  = CNT_W'(RESET_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(RESET_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  UNIT      = CNT_W'(DELAY_UNIT);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LOW,
    S_RST_WAIT,
    S_FETCH,
    S_SEND,
    S_DELAY,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        word_q, word_d;
  logic              resx_q, resx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic              consume;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      resx_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      resx_q  <= resx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    word_d  = word_q;
    resx_d  = resx_q;
    busy_d  = busy_q;
    done_d  = done_q;
    valid_d = valid_q;
    consume = 1'b0;

    case (state_q)
      S_IDLE, S_FIN: begin
        if (start_i) begin
          state_d = S_RST_LOW;
          cnt_d   = '0;
          addr_d  = '0;
          resx_d  = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_RST_LOW: begin
        if (cnt_q == LOW_LAST) begin
          state_d = S_RST_WAIT;
          cnt_d   = '0;
          resx_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FETCH: begin
        if (!bus.rom_data[9]) begin
          state_d = S_SEND;
          word_d  = bus.rom_data[8:0];
          valid_d = 1'b1;
        end else if (bus.rom_data[7:0] == 8'd0) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          // Counts down to zero inclusive, so load one less than the cycle total.
          state_d = S_DELAY;
          cnt_d   = CNT_W'(bus.rom_data[7:0]) * UNIT - CNT_W'(1);
        end
      end
      S_SEND: begin
        if (bus.tx_ready) begin
          valid_d = 1'b0;
          consume = 1'b1;
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          consume = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The last table slot ends the run instead of wrapping back to address 0.
    if (consume) begin
      if (addr_q == ADDR_LAST) begin
        state_d = S_FIN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = S_FETCH;
        addr_d  = addr_q + 1'b1;
      end
    end
  end

  assign resx_o       = resx_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign bus.rom_addr = addr_q;
  assign bus.tx_valid = valid_q;
  assign bus.tx_word  = word_q;

endmodule

// File: tb/tb_lcd_init_seq.sv
// tb/tb_lcd_init_seq.sv - self-checking bench for lcd_init_seq with a table-walking timing model
module tb_lcd_init_seq;

  localparam int RDY_N = 4096;
  localparam int HS_N  = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, busy, done, resx;
  lcd_init_seq_if #(.ADDR_W(8)) bus ();

  logic [9:0] rom [256];
  bit         rdy [RDY_N];
  assign bus.rom_data = rom[bus.rom_addr];

  lcd_init_seq #(
    .RESET_LOW_CYCLES (4),
    .RESET_WAIT_CYCLES(8),
    .DELAY_UNIT       (3),
    .ADDR_W           (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start_i(start),
    .busy_o (busy),
    .done_o (done),
    .resx_o (resx),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0][9:0] ent;
    int              stall;
    int              fin;
    int              addr;
    int              nhs;
    int              c0;
    int              vc;
    logic [8:0]      w0;
    logic [8:0]      wl;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc, nhs, fin_cyc, fin_addr, resx_low, resx_rise, busy_bad, stable_bad, vcyc;
  logic [8:0] hs_word [HS_N];
  int         hs_cyc  [HS_N];
  logic [8:0] exp_word [HS_N];
  int         exp_cyc  [HS_N];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input logic [9:0] e0, e1, e2, e3, input int stall, fin, addr,
                              nhs_e, c0, vc, input logic [8:0] w0, wl);
    vec_t r;
    r.ent   = {e3, e2, e1, e0};
    r.stall = stall;
    r.fin   = fin;
    r.addr  = addr;
    r.nhs   = nhs_e;
    r.c0    = c0;
    r.vc    = vc;
    r.w0    = w0;
    r.wl    = wl;
    return r;
  endfunction

  // Walks the table entry by entry: cycle 13 is the first fetch after 4 low + 8 wait cycles.
  function automatic void model(output int fin, output int addr, output int nw);
    int t;
    int a;
    logic [9:0] e;
    t = 13; a = 0; nw = 0; fin = -1; addr = -1;
    while (fin < 0) begin
      e = rom[a];
      t++;
      if (!e[9]) begin
        while (t < RDY_N && !rdy[t]) t++;
        exp_word[nw] = e[8:0];
        exp_cyc[nw]  = t;
        nw++;
        t++;
      end else if (e[7:0] == 8'd0) begin
        fin = t;
        addr = a;
      end else begin
        t += int'(e[7:0]) * 3;
      end
      if (fin < 0 && a == 255) begin
        fin = t;
        addr = 255;
      end
      a++;
    end
  endfunction

  // Cycle k is the state after the k-th rising edge following the one that samples START.
  task automatic run_seq(input int budget);
    logic       pv;
    logic [8:0] pw;
    nhs = 0; fin_cyc = -1; fin_addr = -1; resx_low = 0; resx_rise = -1;
    busy_bad = 0; stable_bad = 0; vcyc = 0; pv = 1'b0; pw = '0;
    for (int i = 0; i < HS_N; i++) begin
      hs_word[i] = '0;
      hs_cyc[i]  = -1;
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (cyc < budget && fin_cyc < 0) begin
      cyc++;
      bus.tx_ready = (cyc < RDY_N) ? rdy[cyc] : 1'b1;
      @(negedge clk);
      if (!resx) resx_low++;
      else if (resx_rise < 0) resx_rise = cyc;
      if (!done && !busy) busy_bad++;
      if (bus.tx_valid) begin
        vcyc++;
        if (pv && bus.tx_word != pw) stable_bad++;
        if (bus.tx_ready) begin
          if (nhs < HS_N) begin
            hs_word[nhs] = bus.tx_word;
            hs_cyc[nhs]  = cyc;
          end
          nhs++;
          pv = 1'b0;
        end else begin
          pv = 1'b1;
          pw = bus.tx_word;
        end
      end else begin
        pv = 1'b0;
      end
      if (done) begin
        fin_cyc  = cyc;
        fin_addr = int'(bus.rom_addr);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v [5];
    int   f, a, n, vsum, mpos;

    v[0] = mk(10'h011, 10'h129, 10'h200, 10'h200, 0, 18, 2, 2, 14, 2, 9'h011, 9'h129);
    v[1] = mk(10'h011, 10'h129, 10'h200, 10'h200, 5, 23, 2, 2, 19, 7, 9'h011, 9'h129);
    v[2] = mk(10'h205, 10'h0A5, 10'h200, 10'h200, 0, 32, 2, 1, 30, 1, 9'h0A5, 9'h0A5);
    v[3] = mk(10'h200, 10'h200, 10'h200, 10'h200, 0, 14, 0, 0, -1, 0, 9'h000, 9'h000);
    v[4] = mk(10'h101, 10'h201, 10'h0FF, 10'h200, 0, 22, 3, 2, 14, 2, 9'h101, 9'h0FF);

    rst = 1'b1;
    start = 1'b0;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 10'h200;
    #2;
    chk("rst_resx", int'(resx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(bus.tx_valid), 0);
    chk("rst_word", int'(bus.tx_word), 0);
    chk("rst_addr", int'(bus.rom_addr), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_resx", int'(resx), 0);

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 256; i++) rom[i] = 10'h200;
      for (int i = 0; i < 4; i++) rom[i] = v[k].ent[i];
      for (int i = 0; i < RDY_N; i++) rdy[i] = !(i >= 14 && i < 14 + v[k].stall);
      run_seq(200);
      chk($sformatf("v%0d_fin", k), fin_cyc, v[k].fin);
      chk($sformatf("v%0d_addr", k), fin_addr, v[k].addr);
      chk($sformatf("v%0d_nhs", k), nhs, v[k].nhs);
      chk($sformatf("v%0d_valid_cycles", k), vcyc, v[k].vc);
      chk($sformatf("v%0d_resx_low", k), resx_low, 4);
      chk($sformatf("v%0d_resx_rise", k), resx_rise, 5);
      chk($sformatf("v%0d_busy_gap", k), busy_bad, 0);
      chk($sformatf("v%0d_word_stable", k), stable_bad, 0);
      if (v[k].nhs > 0) begin
        chk($sformatf("v%0d_first_word", k), int'(hs_word[0]), int'(v[k].w0));
        chk($sformatf("v%0d_first_cycle", k), hs_cyc[0], v[k].c0);
        chk($sformatf("v%0d_last_word", k), int'(hs_word[v[k].nhs-1]), int'(v[k].wl));
      end
    end

    for (int r = 0; r < 6; r++) begin
      mpos = $urandom_range(20, 3);
      for (int i = 0; i < 256; i++) begin
        if ($urandom_range(4, 0) == 0) rom[i] = {2'b10, 8'($urandom_range(4, 1))};
        else rom[i] = {1'b0, 9'($urandom)};
      end
      rom[mpos] = 10'h200;
      for (int i = 0; i < RDY_N; i++) rdy[i] = ($urandom_range(3, 0) != 0);
      model(f, a, n);
      run_seq(3000);
      chk($sformatf("rnd%0d_fin", r), fin_cyc, f);
      chk($sformatf("rnd%0d_addr", r), fin_addr, a);
      chk($sformatf("rnd%0d_nhs", r), nhs, n);
      chk($sformatf("rnd%0d_stable", r), stable_bad, 0);
      for (int i = 0; i < n && i < nhs; i++) begin
        chk($sformatf("rnd%0d_word%0d", r, i), int'(hs_word[i]), int'(exp_word[i]));
        chk($sformatf("rnd%0d_cyc%0d", r, i), hs_cyc[i], exp_cyc[i]);
      end
    end

    for (int i = 0; i < 256; i++) rom[i] = {1'b0, 9'($urandom)};
    for (int i = 0; i < RDY_N; i++) rdy[i] = 1'b1;
    run_seq(700);
    chk("end_fin", fin_cyc, 525);
    chk("end_addr", fin_addr, 255);
    chk("end_nhs", nhs, 256);
    chk("end_last_word", int'(hs_word[255]), int'(rom[255][8:0]));
    vsum = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.tx_valid || bus.rom_addr != 8'd255 || !done) vsum++;
    end
    chk("end_hold", vsum, 0);

    for (int i = 0; i < 256; i++) rom[i] = 10'h200;
    rom[0] = 10'h205;
    rom[1] = 10'h0A5;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (18) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("busy_start_resx", int'(resx), 1);
    chk("busy_start_busy", int'(busy), 1);
    chk("busy_start_addr", int'(bus.rom_addr), 0);
    #2 rst = 1'b1;
    #1;
    chk("abort_delay_resx", int'(resx), 0);
    chk("abort_delay_busy", int'(busy), 0);
    chk("abort_delay_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    vsum = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || done || bus.tx_valid || resx) vsum++;
    end
    chk("abort_delay_stay_idle", vsum, 0);

    rom[0] = 10'h011;
    rom[1] = 10'h129;
    bus.tx_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(negedge clk);
    chk("abort_send_valid", int'(bus.tx_valid), 1);
    chk("abort_send_word", int'(bus.tx_word), 9'h011);
    #2 rst = 1'b1;
    #1;
    chk("abort_send_drop", int'(bus.tx_valid), 0);
    chk("abort_send_word_clr", int'(bus.tx_word), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.tx_ready = 1'b1;
    vsum = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.tx_valid || busy) vsum++;
    end
    chk("abort_send_no_xfer", vsum, 0);

    for (int i = 0; i < RDY_N; i++) rdy[i] = 1'b1;
    rom[2] = 10'h200;
    run_seq(200);
    chk("restart_fin", fin_cyc, 18);
    chk("restart_nhs", nhs, 2);
    chk("restart_resx_low", resx_low, 4);
    chk("restart_w1", int'(hs_word[1]), 9'h129);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
